// File: rtl/mem_pkg.sv
// Shared definitions for the unified byte memory.
// Holds the access-type enum, the default parameter values and the fault
// function used by the top level to range-check and write-protect accesses.
package mem_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DREAD  = 2'd1,
        DWRITE = 2'd2
    } access_e;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 12;
    localparam int DEF_DEPTH        = 4096;
    localparam int DEF_IMEM_LIMIT   = 1024;
    localparam bit DEF_PROTECT_IMEM = 1'b1;
    localparam int DEF_STARVE_LIM   = 3;

    // Decide whether an access faults. The span is one byte in byte mode and a
    // full word otherwise. Fetches must stay inside the instruction region.
    // Data accesses must stay inside the array. Protected writes may not touch
    // the instruction region; the lowest byte written is at addr, so checking
    // addr alone covers every byte of the access.
    function automatic logic access_fault(
        input int unsigned addr,
        input access_e     kind,
        input logic        byte_mode,
        input int unsigned bytes,
        input int unsigned depth,
        input int unsigned imem_limit,
        input logic        protect
    );
        int unsigned span;
        int unsigned end_excl;
        logic        fault;
        span     = byte_mode ? 32'd1 : bytes;
        end_excl = addr + span;
        fault    = 1'b0;
        case (kind)
            FETCH:   fault = (end_excl > imem_limit);
            DREAD:   fault = (end_excl > depth);
            DWRITE:  fault = (end_excl > depth) || (protect && (addr < imem_limit));
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter with a starvation guard.
// The data port wins conflicts until fetch has lost STARVE_LIM consecutive
// conflicts; fetch then wins the next one and the loss counter clears.
// Ports:
//   clk, rest       clock and asynchronous active-low reset
//   if_req_i        fetch request
//   d_req_i         data request
//   if_gnt_o        fetch granted this cycle (combinational)
//   d_gnt_o         data granted this cycle (combinational)
module mem_arbiter #(
    parameter int STARVE_LIM = 3
) (
    input  logic clk,
    input  logic rest,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic if_gnt_o,
    output logic d_gnt_o
);

    localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             conflict;
    logic             fetch_wins;

    // Grants are forced low while reset is held so neither port is accepted.
    always_comb begin
        conflict     = if_req_i && d_req_i;
        fetch_wins   = conflict && (starve_cnt_q == CNT_W'(STARVE_LIM));
        if_gnt_o     = rest && if_req_i && (!d_req_i || fetch_wins);
        d_gnt_o      = rest && d_req_i && !fetch_wins;
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i || if_gnt_o) begin
            starve_cnt_d = '0;
        end else if (conflict) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/unified_byte_memory.sv
// Byte-addressed, big-endian storage shared by a fetch port and a data port.
// One access per cycle is chosen by mem_arbiter; its response is registered
// and presented for exactly one cycle after the accepting edge.
// Ports:
//   clk, rest                         clock and asynchronous active-low reset
//   if_req/if_addr                    fetch request and byte address
//   if_ready/if_valid/if_rdata/if_fault  fetch accept and registered response
//   d_req/d_we/d_byte/d_addr/d_wdata  data request, direction, mode, address, data
//   d_ready/d_valid/d_rdata/d_fault   data accept and registered response
module unified_byte_memory
    import mem_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int IMEM_LIMIT   = DEF_IMEM_LIMIT,
    parameter bit PROTECT_IMEM = DEF_PROTECT_IMEM,
    parameter int STARVE_LIM   = DEF_STARVE_LIM
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_fault,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_fault
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    // Bytes are stored XOR-ed with the low address bits, so the power-up
    // all-zero array reads back as mem[i] = i[7:0] without any reset clear.
    logic [7:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] acc_addr;
    access_e           acc_kind;
    logic              acc_byte;
    logic              acc_fault;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    logic              if_valid_q, if_valid_d;
    logic              if_fault_q, if_fault_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_valid_q, d_valid_d;
    logic              d_fault_q, d_fault_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    mem_arbiter #(
        .STARVE_LIM(STARVE_LIM)
    ) u_arb (
        .clk      (clk),
        .rest     (rest),
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .if_gnt_o (if_ready),
        .d_gnt_o  (d_ready)
    );

    // The granted port drives the single shared access path.
    always_comb begin
        acc_addr  = d_ready ? d_addr : if_addr;
        acc_kind  = d_ready ? (d_we ? DWRITE : DREAD) : FETCH;
        acc_byte  = d_ready && d_byte;
        acc_fault = access_fault({{(32-ADDR_W){1'b0}}, acc_addr}, acc_kind, acc_byte,
                                 BYTES, DEPTH, IMEM_LIMIT, PROTECT_IMEM);
        wr_en     = d_ready && d_we && !acc_fault;
    end

    // Big-endian word assembly; lanes past the end of the array read as zero
    // (those accesses fault and their data is discarded anyway).
    always_comb begin
        logic [ADDR_W:0] idx;
        rd_word = '0;
        idx     = '0;
        for (int b = 0; b < BYTES; b++) begin
            idx = {1'b0, acc_addr} + (ADDR_W+1)'(b);
            if (int'(idx) < DEPTH && (!acc_byte || b == 0)) begin
                if (acc_byte) begin
                    rd_word[7:0] = mem_q[idx[IDX_W-1:0]] ^ idx[7:0];
                end else begin
                    rd_word[DATA_W-1-8*b -: 8] = mem_q[idx[IDX_W-1:0]] ^ idx[7:0];
                end
            end
        end
    end

    // Storage is written at the accepting edge and is never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                logic [ADDR_W:0] widx;
                widx = {1'b0, acc_addr} + (ADDR_W+1)'(b);
                if (d_byte) begin
                    if (b == 0) begin
                        mem_q[widx[IDX_W-1:0]] <= d_wdata[7:0] ^ widx[7:0];
                    end
                end else begin
                    mem_q[widx[IDX_W-1:0]] <= d_wdata[DATA_W-1-8*b -: 8] ^ widx[7:0];
                end
            end
        end
    end

    // Response data is zeroed on faults and on write acknowledges.
    always_comb begin
        if_valid_d = if_ready;
        if_fault_d = if_ready && acc_fault;
        if_rdata_d = (if_ready && !acc_fault) ? rd_word : '0;
        d_valid_d  = d_ready;
        d_fault_d  = d_ready && acc_fault;
        d_rdata_d  = (d_ready && !d_we && !acc_fault) ? rd_word : '0;
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            if_valid_q <= 1'b0;
            if_fault_q <= 1'b0;
            if_rdata_q <= '0;
            d_valid_q  <= 1'b0;
            d_fault_q  <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            if_valid_q <= if_valid_d;
            if_fault_q <= if_fault_d;
            if_rdata_q <= if_rdata_d;
            d_valid_q  <= d_valid_d;
            d_fault_q  <= d_fault_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_fault = if_fault_q;
    assign if_rdata = if_rdata_q;
    assign d_valid  = d_valid_q;
    assign d_fault  = d_fault_q;
    assign d_rdata  = d_rdata_q;

endmodule
